key_event_ctrl: RTL and testbench

Converts the debounced push-button vector into a stream of timestamped-free key events (press, release, long-press, auto-repeat) for the PicoRV32 peripheral bus. Sits directly behind the per-bit debouncers and schedules their outputs into one shared event FIFO. A round-robin arbiter resolves simultaneous events from several keys. The CPU drains the FIFO through a valid/ready handshake.

---
 rtl/key_event_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_key_event_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_ctrl.sv
// Turns debounced key levels into PRESS/RELEASE/LONG/REPEAT events.
// Per-key FSMs feed one-deep pending slots, which a round-robin arbiter moves into a shared event FIFO.
module key_event_ctrl #(
   parameter int NUMKEYS      = 3,
   parameter int TICK_CYCLES  = 50_000,
   parameter int LONG_TICKS   = 800,
   parameter int REPEAT_TICKS = 200,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic [NUMKEYS-1:0]              i_keys,
   output logic                            o_evt_valid,
   output logic [7:0]                      o_evt_code,
   input  logic                            i_evt_ready,
   output logic [$clog2(FIFO_DEPTH):0]     o_fifo_count,
   output logic                            o_overflow,
   input  logic                            i_ovf_clr
);
   localparam int HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int CW       = $clog2(HOLD_MAX + 1);
   localparam int PW       = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int IW       = (NUMKEYS > 1) ? $clog2(NUMKEYS) : 1;
   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int FCW      = AW + 1;

   localparam logic [CW:0]   LONG_C   = (CW+1)'(LONG_TICKS);
   localparam logic [CW:0]   REPEAT_C = (CW+1)'(REPEAT_TICKS);
   localparam logic [PW-1:0] PRESC_TC = PW'(TICK_CYCLES - 1);
   localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

   localparam logic [1:0] EV_PRESS   = 2'b00;
   localparam logic [1:0] EV_RELEASE = 2'b01;
   localparam logic [1:0] EV_LONG    = 2'b10;
   localparam logic [1:0] EV_REPEAT  = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_RPT} state_t;

   logic [PW-1:0]      presc_q, presc_d;
   logic               tick;
   logic [NUMKEYS-1:0] key_q, key_d;
   logic [NUMKEYS-1:0] rise, fall;
   logic [NUMKEYS-1:0] pend_valid;
   logic [1:0]         pend_type [NUMKEYS];
   logic [NUMKEYS-1:0] drop;
   logic [NUMKEYS-1:0] grant_vec;
   logic               grant_any;
   logic [IW-1:0]      grant_idx;
   logic [IW-1:0]      rr_q, rr_d;
   logic               ovf_q, ovf_d;

   logic [7:0]         fifo_mem [FIFO_DEPTH];
   logic [AW-1:0]      wr_q, wr_d, rd_q, rd_d;
   logic [FCW-1:0]     fcnt_q, fcnt_d;
   logic               push, pop, fifo_can_push;
   logic [7:0]         push_code;

   // Shared hold-timer prescaler
   always_comb begin
      tick    = (presc_q == PRESC_TC);
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   assign key_d = i_keys;
   assign rise  = i_keys & ~key_q;
   assign fall  = ~i_keys & key_q;

   generate
      for (genvar gi = 0; gi < NUMKEYS; gi++) begin : g_key
         state_t        state_q, state_d;
         logic [CW-1:0] hcnt_q, hcnt_d;
         logic [CW:0]   hcnt_inc;
         logic          key_emit;
         logic [1:0]    key_type;
         logic          pend_v_q, pend_v_d;
         logic [1:0]    pend_t_q, pend_t_d;
         logic          key_drop;

         always_comb begin
            state_d  = state_q;
            hcnt_d   = hcnt_q;
            key_emit = 1'b0;
            key_type = EV_PRESS;
            hcnt_inc = {1'b0, hcnt_q} + 1'b1;
            case (state_q)
               ST_IDLE: begin
                  // A fall here means the key was held through reset: stay silent.
                  if (rise[gi]) begin
                     key_emit = 1'b1;
                     key_type = EV_PRESS;
                     state_d  = ST_HELD;
                     hcnt_d   = '0;
                  end
               end
               ST_HELD: begin
                  if (fall[gi]) begin
                     key_emit = 1'b1;
                     key_type = EV_RELEASE;
                     state_d  = ST_IDLE;
                     hcnt_d   = '0;
                  end else if (tick) begin
                     if (hcnt_inc == LONG_C) begin
                        key_emit = 1'b1;
                        key_type = EV_LONG;
                        state_d  = ST_RPT;
                        hcnt_d   = '0;
                     end else begin
                        hcnt_d = hcnt_inc[CW-1:0];
                     end
                  end
               end
               ST_RPT: begin
                  if (fall[gi]) begin
                     key_emit = 1'b1;
                     key_type = EV_RELEASE;
                     state_d  = ST_IDLE;
                     hcnt_d   = '0;
                  end else if (tick) begin
                     if (hcnt_inc == REPEAT_C) begin
                        key_emit = 1'b1;
                        key_type = EV_REPEAT;
                        hcnt_d   = '0;
                     end else begin
                        hcnt_d = hcnt_inc[CW-1:0];
                     end
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  hcnt_d  = '0;
               end
            endcase
         end

         // A slot freed by this cycle's grant can take a new event immediately.
         always_comb begin
            pend_v_d = pend_v_q & ~grant_vec[gi];
            pend_t_d = pend_t_q;
            key_drop = 1'b0;
            if (key_emit) begin
               if (pend_v_d) begin
                  key_drop = 1'b1;
               end else begin
                  pend_v_d = 1'b1;
                  pend_t_d = key_type;
               end
            end
         end

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               state_q  <= ST_IDLE;
               hcnt_q   <= '0;
               pend_v_q <= 1'b0;
               pend_t_q <= EV_PRESS;
            end else begin
               state_q  <= state_d;
               hcnt_q   <= hcnt_d;
               pend_v_q <= pend_v_d;
               pend_t_q <= pend_t_d;
            end
         end

         assign pend_valid[gi] = pend_v_q;
         assign pend_type[gi]  = pend_t_q;
         assign drop[gi]       = key_drop;
      end
   endgenerate

   // Round-robin search begins at the key after the last one granted.
   always_comb begin
      int            idx;
      logic [IW-1:0] cand;
      grant_any = 1'b0;
      grant_idx = rr_q;
      grant_vec = '0;
      idx       = 0;
      cand      = '0;
      for (int i = 1; i <= NUMKEYS; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUMKEYS) idx = idx - NUMKEYS;
         cand = IW'(idx);
         if (!grant_any && fifo_can_push && pend_valid[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
         end
      end
      if (grant_any) grant_vec[grant_idx] = 1'b1;
      rr_d = grant_any ? grant_idx : rr_q;
   end

   assign o_evt_valid   = (fcnt_q != '0);
   assign pop           = o_evt_valid & i_evt_ready;
   assign fifo_can_push = (fcnt_q < DEPTH_C) | pop;
   assign push          = grant_any;
   assign push_code     = {pend_type[grant_idx], 6'(grant_idx)};

   always_comb begin
      wr_d   = wr_q;
      rd_d   = rd_q;
      fcnt_d = fcnt_q;
      if (push) wr_d = wr_q + 1'b1;
      if (pop)  rd_d = rd_q + 1'b1;
      case ({push, pop})
         2'b10:   fcnt_d = fcnt_q + 1'b1;
         2'b01:   fcnt_d = fcnt_q - 1'b1;
         default: fcnt_d = fcnt_q;
      endcase
      ovf_d = (ovf_q & ~i_ovf_clr) | (|drop);
   end

   always_ff @(posedge i_clk) begin
      if (push) fifo_mem[wr_q] <= push_code;
   end

   always_ff @(posedge i_clk) begin
      key_q <= key_d;
      if (i_rst) begin
         presc_q <= '0;
         rr_q    <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         fcnt_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         presc_q <= presc_d;
         rr_q    <= rr_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         fcnt_q  <= fcnt_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage is not cleared, so mask the head while the FIFO is empty.
   assign o_evt_code   = o_evt_valid ? fifo_mem[rd_q] : 8'h00;
   assign o_fifo_count = fcnt_q;
   assign o_overflow   = ovf_q;
endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: vector table for cycle-exact FIFO/overflow
// behaviour plus hand-written sequences for hold timing, arbitration and reset.
module tb_key_event_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] keys;
   logic       evt_valid;
   logic [7:0] evt_code;
   logic       evt_ready;
   logic [2:0] fifo_count;
   logic       overflow;
   logic       ovf_clr;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   key_event_ctrl #(
      .NUMKEYS(3), .TICK_CYCLES(4), .LONG_TICKS(3), .REPEAT_TICKS(2), .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_keys(keys),
      .o_evt_valid(evt_valid), .o_evt_code(evt_code), .i_evt_ready(evt_ready),
      .o_fifo_count(fifo_count), .o_overflow(overflow), .i_ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [7:0] code;
      logic [31:0] stamp;
   } ev_t;
   ev_t evq[$];

   // Record every accepted head event with the cycle it was popped in.
   always @(negedge clk) begin
      if (!rst && evt_valid && evt_ready) begin
         evq.push_back('{code: evt_code, stamp: 32'(cyc)});
         $display("evt code=%02h cyc=%0d", evt_code, cyc);
      end
   end

   typedef struct packed {
      logic [2:0] keys;
      logic       rdy;
      logic       clr;
      logic       ev;
      logic [7:0] ec;
      logic [2:0] cnt;
      logic       ovf;
   } vec_t;
   vec_t tab[$];

   task automatic v(input logic [2:0] k, input logic r, input logic c,
                    input logic e, input logic [7:0] ec, input logic [2:0] n, input logic o);
      vec_t t;
      t.keys = k; t.rdy = r; t.clr = c; t.ev = e; t.ec = ec; t.cnt = n; t.ovf = o;
      tab.push_back(t);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_table(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         keys = tab[i].keys; evt_ready = tab[i].rdy; ovf_clr = tab[i].clr;
         step(1);
         $display("vec %0d keys=%b rdy=%b clr=%b -> valid=%b code=%02h count=%0d ovf=%b",
                  i, tab[i].keys, tab[i].rdy, tab[i].clr, evt_valid, evt_code, fifo_count, overflow);
         check($sformatf("v%0d_valid", i), int'(evt_valid), int'(tab[i].ev));
         check($sformatf("v%0d_code", i), int'(evt_code), int'(tab[i].ec));
         check($sformatf("v%0d_count", i), int'(fifo_count), int'(tab[i].cnt));
         check($sformatf("v%0d_ovf", i), int'(overflow), int'(tab[i].ovf));
      end
   endtask

   task automatic check_codes(input string name, input int base, input logic [7:0] c0,
                              input logic [7:0] c1, input logic [7:0] c2);
      logic [7:0] exp [3];
      exp[0] = c0; exp[1] = c1; exp[2] = c2;
      for (int i = 0; i < 3; i++) begin
         if (evq.size() > base + i)
            check($sformatf("%s_%0d", name, i), int'(evq[base+i].code), int'(exp[i]));
         else
            check($sformatf("%s_%0d_missing", name, i), evq.size(), base + i + 1);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int long_d;
      int found;

      // Table A: reset with key1 held, release it silently, then a 2-cycle key0 press.
      v(3'b010,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b000,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b000,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b001,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b001,1'b1,1'b0, 1'b1,8'h00,3'd1,1'b0);
      v(3'b000,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b000,1'b1,1'b0, 1'b1,8'h40,3'd1,1'b0);
      v(3'b000,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);
      // Table B (8..39): fill with ready low, drops, drain, then push+pop at full and clear-vs-drop.
      v(3'b001,1'b0,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd1,1'b0);
      v(3'b001,1'b0,1'b0, 1'b1,8'h00,3'd2,1'b0);
      v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd3,1'b0);
      v(3'b001,1'b0,1'b0, 1'b1,8'h00,3'd4,1'b0);
      v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd4,1'b1);
      for (int i = 0; i < 3; i++) begin
         v(3'b001,1'b0,1'b0, 1'b1,8'h00,3'd4,1'b1);
         v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd4,1'b1);
      end
      v(3'b000,1'b1,1'b0, 1'b1,8'h40,3'd4,1'b1);
      v(3'b000,1'b1,1'b0, 1'b1,8'h00,3'd3,1'b1);
      v(3'b000,1'b1,1'b0, 1'b1,8'h40,3'd2,1'b1);
      v(3'b000,1'b1,1'b0, 1'b1,8'h00,3'd1,1'b1);
      v(3'b000,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b1);
      v(3'b000,1'b1,1'b1, 1'b0,8'h00,3'd0,1'b0);
      v(3'b001,1'b0,1'b0, 1'b0,8'h00,3'd0,1'b0);
      v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd1,1'b0);
      v(3'b001,1'b0,1'b0, 1'b1,8'h00,3'd2,1'b0);
      v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd3,1'b0);
      v(3'b001,1'b0,1'b0, 1'b1,8'h00,3'd4,1'b0);
      v(3'b000,1'b0,1'b0, 1'b1,8'h00,3'd4,1'b1);
      v(3'b001,1'b0,1'b1, 1'b1,8'h00,3'd4,1'b1);
      v(3'b001,1'b0,1'b1, 1'b1,8'h00,3'd4,1'b0);
      v(3'b000,1'b1,1'b0, 1'b1,8'h40,3'd4,1'b0);
      v(3'b000,1'b1,1'b0, 1'b1,8'h00,3'd4,1'b0);
      v(3'b000,1'b1,1'b0, 1'b1,8'h40,3'd3,1'b0);
      v(3'b000,1'b1,1'b0, 1'b1,8'h00,3'd2,1'b0);
      v(3'b000,1'b1,1'b0, 1'b1,8'h40,3'd1,1'b0);
      v(3'b000,1'b1,1'b0, 1'b0,8'h00,3'd0,1'b0);

      rst = 1'b1; keys = 3'b010; evt_ready = 1'b1; ovf_clr = 1'b0;
      step(2);
      check("rst_valid", int'(evt_valid), 0);
      check("rst_code", int'(evt_code), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_ovf", int'(overflow), 0);
      rst = 1'b0;
      run_table(0, 7);

      // Long hold on key2: PRESS, LONG after 9..12 cycles, REPEAT every 8, RELEASE.
      evq.delete();
      keys = 3'b100;
      step(30);
      keys = 3'b000;
      step(5);
      check("hold_events", evq.size(), 5);
      if (evq.size() == 5) begin
         check("hold_c0", int'(evq[0].code), 8'h02);
         check("hold_c1", int'(evq[1].code), 8'h82);
         check("hold_c2", int'(evq[2].code), 8'hC2);
         check("hold_c3", int'(evq[3].code), 8'hC2);
         check("hold_c4", int'(evq[4].code), 8'h42);
         long_d = int'(evq[1].stamp) - int'(evq[0].stamp);
         check("long_delay_in_9_12", int'(long_d >= 9 && long_d <= 12), 1);
         check("repeat_gap1", int'(evq[2].stamp) - int'(evq[1].stamp), 8);
         check("repeat_gap2", int'(evq[3].stamp) - int'(evq[2].stamp), 8);
         check("release_delay", int'(evq[4].stamp) - int'(evq[0].stamp), 30);
      end
      check("hold_no_ovf", int'(overflow), 0);

      // Simultaneous rises; last grant was key2, so key0 goes first.
      evq.delete();
      keys = 3'b111;
      step(4);
      keys = 3'b000;
      step(6);
      check("rr_events", evq.size(), 6);
      check_codes("rr_press", 0, 8'h00, 8'h01, 8'h02);
      if (evq.size() >= 3) begin
         check("rr_back2back1", int'(evq[1].stamp) - int'(evq[0].stamp), 1);
         check("rr_back2back2", int'(evq[2].stamp) - int'(evq[1].stamp), 1);
      end
      check_codes("rr_release", 3, 8'h40, 8'h41, 8'h42);

      // Leave the pointer at key1, then rise all three again.
      keys = 3'b010;
      step(2);
      keys = 3'b000;
      step(4);
      evq.delete();
      keys = 3'b111;
      step(4);
      keys = 3'b000;
      step(6);
      check("rr1_events", evq.size(), 6);
      check_codes("rr1_press", 0, 8'h02, 8'h00, 8'h01);
      check_codes("rr1_release", 3, 8'h42, 8'h40, 8'h41);

      run_table(8, 19);
      evq.delete();
      run_table(20, 25);
      check("drain_events", evq.size(), 5);
      for (int i = 0; i < 5 && i < evq.size(); i++)
         check($sformatf("drain_c%0d", i), int'(evq[i].code), (i % 2 == 0) ? 8'h00 : 8'h40);
      run_table(26, 39);

      // Reset while key1 repeats with PRESS and LONG queued.
      evt_ready = 1'b0;
      keys = 3'b010;
      found = 0;
      for (int i = 0; i < 20 && found == 0; i++) begin
         step(1);
         if (fifo_count == 3'd2) found = 1;
      end
      check("rpt_two_queued", found, 1);
      if (found == 1) check("rpt_head_press", int'(evt_code), 8'h01);
      step(1);
      rst = 1'b1;
      step(1);
      check("midrst_valid", int'(evt_valid), 0);
      check("midrst_count", int'(fifo_count), 0);
      check("midrst_code", int'(evt_code), 0);
      rst = 1'b0;
      step(2);
      keys = 3'b000;
      step(5);
      check("post_rst_no_release_count", int'(fifo_count), 0);
      check("post_rst_no_release_valid", int'(evt_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
